// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and the two-port ALU arbiter.
//
// Contents:
//   - ALUSel opcode constants ALU_ADD..ALU_SRA
//   - ALU_OP_MAX, the highest legal opcode
//   - ALU_TAG_W, the tag width carried in the response struct
//   - alu_rsp_t, the registered response (data, id, tag, err)
//   - alu_op_legal(), true when an opcode is inside 0x0..ALU_OP_MAX
// -----------------------------------------------------------------------------
package alu_pkg;

   // ALUSel encoding seen by the ALU and by both requesters
   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_SUB  = 4'h1;
   localparam logic [3:0] ALU_AND  = 4'h2;
   localparam logic [3:0] ALU_OR   = 4'h3;
   localparam logic [3:0] ALU_SLL  = 4'h4;
   localparam logic [3:0] ALU_SRL  = 4'h5;
   localparam logic [3:0] ALU_XOR  = 4'h6;
   localparam logic [3:0] ALU_SLT  = 4'h7;
   localparam logic [3:0] ALU_SLTU = 4'h8;
   localparam logic [3:0] ALU_SLA  = 4'h9;
   localparam logic [3:0] ALU_SRA  = 4'hA;

   localparam logic [3:0] ALU_OP_MAX = 4'hA;

   // Tag width stored in the response struct; the arbiter's TAG_W is
   // expected to match this value.
   localparam int ALU_TAG_W = 4;

   // One-entry response buffer contents
   typedef struct packed {
      logic [31:0]          data;
      logic                 id;
      logic [ALU_TAG_W-1:0] tag;
      logic                 err;
   } alu_rsp_t;

   // Opcodes above ALU_OP_MAX are reserved and flagged as errors
   function automatic logic alu_op_legal(input logic [3:0] sel);
      return (sel <= ALU_OP_MAX);
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the two request channels and the response channel of the ALU
// arbiter.
//
// Signals:
//   req0_* / req1_* : valid, ready, a, b, sel, tag for port 0 / port 1
//   rsp_*           : valid, ready, data, id, tag, err for the response
//
// Modports:
//   slave  : the arbiter side (takes requests, drives responses)
//   master : the requester / consumer side
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
   parameter int TAG_W = alu_pkg::ALU_TAG_W
);

   logic             req0_valid;
   logic             req0_ready;
   logic [31:0]      req0_a;
   logic [31:0]      req0_b;
   logic [3:0]       req0_sel;
   logic [TAG_W-1:0] req0_tag;

   logic             req1_valid;
   logic             req1_ready;
   logic [31:0]      req1_a;
   logic [31:0]      req1_b;
   logic [3:0]       req1_sel;
   logic [TAG_W-1:0] req1_tag;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_data;
   logic             rsp_id;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_err;

   // Arbiter view: requests and rsp_ready come in, readys and response go out
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_sel, req0_tag,
      input  req1_valid, req1_a, req1_b, req1_sel, req1_tag,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_data, rsp_id, rsp_tag, rsp_err
   );

   // Requester / consumer view
   modport master (
      output req0_valid, req0_a, req0_b, req0_sel, req0_tag,
      output req1_valid, req1_a, req1_b, req1_sel, req1_tag,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_data, rsp_id, rsp_tag, rsp_err
   );

endinterface

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational 32-bit integer ALU using the ALUSel encoding.
//
// Ports:
//   a, b   in  32  operands; shifts use the whole 32-bit b as the amount
//   sel    in  4   ALUSel opcode
//   result out 32  operation result (0 for reserved opcodes)
//   err    out 1   opcode outside 0x0..ALU_OP_MAX
// -----------------------------------------------------------------------------
module alu
   import alu_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  sel,
   output logic [31:0] result,
   output logic        err
);

   // Operation select. Shift amounts are deliberately the full 32-bit b, so
   // any amount of 32 or more shifts everything out (sign-filled for sra).
   // sla is a left shift, which for two's complement is identical to sll.
   always_comb begin
      result = '0;
      err    = ~alu_op_legal(sel);
      case (sel)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_SLL:  result = a << b;
         ALU_SRL:  result = a >> b;
         ALU_XOR:  result = a ^ b;
         ALU_SLT:  result = {31'b0, ($signed(a) < $signed(b))};
         ALU_SLTU: result = {31'b0, (a < b)};
         ALU_SLA:  result = a << b;
         ALU_SRA:  result = $signed(a) >>> b;
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between port 0 (execute stage) and port 1 (auxiliary
// sequencer). Arbitrates between the two valid/ready request channels, drives
// the ALU from the winner and registers the result, requester id, tag and
// error flag into a one-entry response buffer (latency 1, 1 op/cycle).
//
// Ports:
//   clk    in  clock, all state on the rising edge
//   reset  in  synchronous active-high reset
//   bus    alu_arbiter_if.slave: req0_*, req1_*, rsp_* channels
//
// Parameters:
//   TAG_W  width of the opaque per-request tag (matches alu_pkg::ALU_TAG_W)
//
// Configuration macro:
//   ALU_ARB_ROUND_ROBIN_EN  defined   : on contention the port that did not
//                                       win the last transfer is granted
//                           undefined : fixed priority, port 0 always wins
// -----------------------------------------------------------------------------
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int TAG_W = ALU_TAG_W
) (
   input  logic         clk,
   input  logic         reset,
   alu_arbiter_if.slave bus
);

   logic             can_accept;
   logic             pick0;
   logic             grant0;
   logic             grant1;
   logic             xfer0;
   logic             xfer1;
   logic             xfer;

   logic [31:0]      alu_a;
   logic [31:0]      alu_b;
   logic [3:0]       alu_sel;
   logic [31:0]      alu_result;
   logic             alu_err;
   logic [TAG_W-1:0] win_tag;

   logic             rsp_valid_d;
   logic             rsp_valid_q;
   alu_rsp_t         rsp_d;
   alu_rsp_t         rsp_q;

`ifdef ALU_ARB_ROUND_ROBIN_EN
   // Id of the port that won the most recent transfer
   logic             last_grant_d;
   logic             last_grant_q;
`endif

   // Contention policy: pick0 says whether port 0 should win when both
   // ports are valid. With round robin that is the case whenever port 1 won
   // the last transfer; otherwise port 0 simply has fixed priority.
   always_comb begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      pick0 = last_grant_q;
`else
      pick0 = 1'b1;
`endif
   end

   // Grant and handshake. The buffer can take a new result when it is empty
   // or being drained this cycle. Grants are recomputed every cycle from the
   // current valids, so a grant is never held for a port that went idle, and
   // ready can only reach a port that is valid. Ready stays low in reset.
   always_comb begin
      can_accept     = ~rsp_valid_q | bus.rsp_ready;
      grant0         = bus.req0_valid & (~bus.req1_valid | pick0);
      grant1         = bus.req1_valid & ~grant0;
      xfer0          = ~reset & can_accept & grant0;
      xfer1          = ~reset & can_accept & grant1;
      xfer           = xfer0 | xfer1;
      bus.req0_ready = xfer0;
      bus.req1_ready = xfer1;
   end

   // Winner operand mux feeding the shared ALU. Port 0 is the default so the
   // ALU sees stable operands when nobody is requesting.
   always_comb begin
      if (grant1) begin
         alu_a   = bus.req1_a;
         alu_b   = bus.req1_b;
         alu_sel = bus.req1_sel;
         win_tag = bus.req1_tag;
      end else begin
         alu_a   = bus.req0_a;
         alu_b   = bus.req0_b;
         alu_sel = bus.req0_sel;
         win_tag = bus.req0_tag;
      end
   end

   alu u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .sel    (alu_sel),
      .result (alu_result),
      .err    (alu_err)
   );

   // Response buffer next state. A drain without a new transfer clears the
   // valid bit but keeps the data fields; a transfer always overwrites the
   // entry, which also covers drain-and-refill in one cycle with no bubble.
   always_comb begin
      rsp_valid_d = rsp_valid_q & ~bus.rsp_ready;
      rsp_d       = rsp_q;
      if (xfer) begin
         rsp_valid_d = 1'b1;
         rsp_d.data  = alu_result;
         rsp_d.id    = grant1;
         rsp_d.tag   = ALU_TAG_W'(win_tag);
         rsp_d.err   = alu_err;
      end
   end

`ifdef ALU_ARB_ROUND_ROBIN_EN
   // The fairness pointer only moves when a transfer actually happens, so a
   // port stalled by backpressure does not lose its turn.
   always_comb begin
      last_grant_d = last_grant_q;
      if (xfer) begin
         last_grant_d = grant1;
      end
   end
`endif

   // State registers. Reset discards any pending response and clears every
   // response field; the pointer resets to 1 so port 0 wins first contention.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q  <= 1'b0;
         rsp_q        <= '0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_q        <= rsp_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   // Response outputs come straight from the registers
   always_comb begin
      bus.rsp_valid = rsp_valid_q;
      bus.rsp_data  = rsp_q.data;
      bus.rsp_id    = rsp_q.id;
      bus.rsp_tag   = TAG_W'(rsp_q.tag);
      bus.rsp_err   = rsp_q.err;
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter: directed scenarios followed by a
// randomized run, all compared against a transaction-level reference model
// of the response buffer and the arbitration rules.
// Honours ALU_ARB_ROUND_ROBIN_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   alu_arbiter_if #(.TAG_W(4)) bus ();

   alu_arbiter #(.TAG_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int num_compared   = 0;
   int num_mismatched = 0;

   // Reference model of the response buffer and fairness pointer
   logic        m_valid = 1'b0;
   logic [31:0] m_data  = '0;
   logic        m_id    = 1'b0;
   logic [3:0]  m_tag   = '0;
   logic        m_err   = 1'b0;
   logic        m_last  = 1'b1;

   // Which ports were accepted in the most recent cycle
   logic        acc0 = 1'b0;
   logic        acc1 = 1'b0;

   // Single comparison point: counts and reports a mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      num_compared++;
      if (observed !== expected) begin
         num_mismatched++;
         $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Arithmetic definition of each opcode; shift amounts of 32 or more empty
   // the word (sign-filled for sra)
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] wide;
      int          sh;
      sh = (b > 32'd31) ? 32 : int'(b);
      case (op)
         4'h0: return a + b;
         4'h1: return a - b;
         4'h2: return a & b;
         4'h3: return a | b;
         4'h4, 4'h9: return (sh == 32) ? 32'h0 : (a << sh);
         4'h5: return (sh == 32) ? 32'h0 : (a >> sh);
         4'h6: return a ^ b;
         4'h7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'h8: return (a < b) ? 32'd1 : 32'd0;
         4'hA: begin
            if (sh == 32) return {32{a[31]}};
            wide = {{32{a[31]}}, a};
            wide = wide >> sh;
            return wide[31:0];
         end
         default: return 32'h0;
      endcase
   endfunction

   task automatic setReq(input int port, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] sel, input logic [3:0] tag);
      if (port == 0) begin
         bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
         bus.req0_sel   = sel; bus.req0_tag = tag;
      end else begin
         bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
         bus.req1_sel   = sel; bus.req1_tag = tag;
      end
   endtask

   // One clock cycle with the currently driven inputs: checks readys against
   // the arbitration rules mid-cycle, advances the model, checks rsp_* after
   // the edge
   task automatic applyStimulus();
      logic        g0, g1, ca, r0, r1, rr, rst;
      logic [31:0] pa, pb;
      logic [3:0]  ps, pt;
      @(negedge clk);
      rst = reset;
      rr  = bus.rsp_ready;
      ca  = !m_valid || rr;
      if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
         g0 = (m_last == 1'b1);
`else
         g0 = 1'b1;
`endif
         g1 = !g0;
      end else begin
         g0 = bus.req0_valid;
         g1 = bus.req1_valid;
      end
      r0 = !rst && ca && g0;
      r1 = !rst && ca && g1;
      checkOutput("req0_ready", {31'b0, bus.req0_ready}, {31'b0, r0});
      checkOutput("req1_ready", {31'b0, bus.req1_ready}, {31'b0, r1});
      if (r1) begin
         pa = bus.req1_a; pb = bus.req1_b; ps = bus.req1_sel; pt = bus.req1_tag;
      end else begin
         pa = bus.req0_a; pb = bus.req0_b; ps = bus.req0_sel; pt = bus.req0_tag;
      end
      @(posedge clk);
      #1;
      acc0 = r0;
      acc1 = r1;
      if (rst) begin
         m_valid = 1'b0; m_data = '0; m_id = 1'b0; m_tag = '0; m_err = 1'b0; m_last = 1'b1;
      end else begin
         if (m_valid && rr) m_valid = 1'b0;
         if (r0 || r1) begin
            m_valid = 1'b1;
            m_data  = ref_alu(ps, pa, pb);
            m_id    = r1;
            m_tag   = pt;
            m_err   = (ps > 4'hA);
            m_last  = r1;
         end
      end
      checkOutput("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, m_valid});
      checkOutput("rsp_data", bus.rsp_data, m_data);
      checkOutput("rsp_id", {31'b0, bus.rsp_id}, {31'b0, m_id});
      checkOutput("rsp_tag", {28'b0, bus.rsp_tag}, {28'b0, m_tag});
      checkOutput("rsp_err", {31'b0, bus.rsp_err}, {31'b0, m_err});
   endtask

   initial begin
      logic        p0, p1;
      logic [31:0] ra, rb;
      logic [31:0] exp_id;

      reset = 1'b1;
      bus.rsp_ready = 1'b0;
      setReq(0, 1'b0, '0, '0, '0, '0);
      setReq(1, 1'b0, '0, '0, '0, '0);
      applyStimulus();
      applyStimulus();
      reset = 1'b0;
      checkOutput("reset_valid", {31'b0, bus.rsp_valid}, 32'd0);
      checkOutput("reset_data", bus.rsp_data, 32'd0);

      // Port 0 alone: add
      bus.rsp_ready = 1'b1;
      setReq(0, 1'b1, 32'd5, 32'd7, ALU_ADD, 4'd3);
      applyStimulus();
      checkOutput("p0_add_data", bus.rsp_data, 32'h0000000C);
      checkOutput("p0_add_tag", {28'b0, bus.rsp_tag}, 32'd3);
      setReq(0, 1'b0, '0, '0, '0, '0);

      // Port 1 alone: sub then sra
      setReq(1, 1'b1, 32'd3, 32'd5, ALU_SUB, 4'd0);
      applyStimulus();
      checkOutput("p1_sub_data", bus.rsp_data, 32'hFFFFFFFE);
      checkOutput("p1_sub_id", {31'b0, bus.rsp_id}, 32'd1);
      setReq(1, 1'b1, 32'h80000000, 32'd4, ALU_SRA, 4'd1);
      applyStimulus();
      checkOutput("p1_sra_data", bus.rsp_data, 32'hF8000000);
      setReq(1, 1'b0, '0, '0, '0, '0);

      // Four cycles of contention
      setReq(0, 1'b1, 32'd10, 32'd1, ALU_ADD, 4'd4);
      setReq(1, 1'b1, 32'd10, 32'd2, ALU_ADD, 4'd5);
      for (int i = 0; i < 4; i++) begin
         applyStimulus();
`ifdef ALU_ARB_ROUND_ROBIN_EN
         exp_id = i % 2;
`else
         exp_id = 32'd0;
`endif
         checkOutput("contend_id", {31'b0, bus.rsp_id}, exp_id);
      end

      // Backpressure with both ports waiting, then drain and refill together
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus();
      bus.rsp_ready = 1'b1;
      applyStimulus();
      checkOutput("no_bubble_valid", {31'b0, bus.rsp_valid}, 32'd1);
      setReq(0, 1'b0, '0, '0, '0, '0);
      setReq(1, 1'b0, '0, '0, '0, '0);

      // Reserved opcode, then unsigned/signed compare
      setReq(0, 1'b1, 32'd1, 32'd1, 4'hC, 4'd6);
      applyStimulus();
      checkOutput("bad_op_data", bus.rsp_data, 32'd0);
      checkOutput("bad_op_err", {31'b0, bus.rsp_err}, 32'd1);
      setReq(0, 1'b1, 32'd1, 32'hFFFFFFFF, ALU_SLTU, 4'd7);
      applyStimulus();
      checkOutput("sltu_data", bus.rsp_data, 32'd1);
      setReq(0, 1'b1, 32'd1, 32'hFFFFFFFF, ALU_SLT, 4'd8);
      applyStimulus();
      checkOutput("slt_data", bus.rsp_data, 32'd0);
      setReq(0, 1'b0, '0, '0, '0, '0);
      applyStimulus();

      // Reset while a response is stalled
      bus.rsp_ready = 1'b0;
      setReq(0, 1'b1, 32'd9, 32'd9, ALU_ADD, 4'd7);
      applyStimulus();
      setReq(0, 1'b0, '0, '0, '0, '0);
      reset = 1'b1;
      applyStimulus();
      reset = 1'b0;
      checkOutput("midrst_valid", {31'b0, bus.rsp_valid}, 32'd0);
      checkOutput("midrst_data", bus.rsp_data, 32'd0);
      checkOutput("midrst_tag", {28'b0, bus.rsp_tag}, 32'd0);
      bus.rsp_ready = 1'b1;
      setReq(0, 1'b1, 32'd2, 32'd2, ALU_OR, 4'd1);
      setReq(1, 1'b1, 32'd3, 32'd3, ALU_OR, 4'd2);
      applyStimulus();
      checkOutput("post_reset_id", {31'b0, bus.rsp_id}, 32'd0);
      setReq(0, 1'b0, '0, '0, '0, '0);
      setReq(1, 1'b0, '0, '0, '0, '0);

      // Randomized traffic; requests hold their payload until accepted
      p0 = 1'b0;
      p1 = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (!p0 && ($urandom % 10) < 6) begin
            ra = $urandom;
            rb = ($urandom % 2) ? $urandom : ($urandom % 40);
            setReq(0, 1'b1, ra, rb, 4'($urandom % 16), 4'($urandom % 16));
            p0 = 1'b1;
         end
         if (!p1 && ($urandom % 10) < 6) begin
            ra = $urandom;
            rb = ($urandom % 2) ? $urandom : ($urandom % 40);
            setReq(1, 1'b1, ra, rb, 4'($urandom % 16), 4'($urandom % 16));
            p1 = 1'b1;
         end
         bus.rsp_ready = (($urandom % 4) != 0);
         reset = (($urandom % 100) == 0);
         applyStimulus();
         reset = 1'b0;
         if (acc0) begin
            p0 = 1'b0;
            setReq(0, 1'b0, '0, '0, '0, '0);
         end
         if (acc1) begin
            p1 = 1'b0;
            setReq(1, 1'b0, '0, '0, '0, '0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single integer ALU between two requesters, port 0 (execute stage) and port 1 (auxiliary sequencer, e.g. address/CSR helper), through valid/ready handshakes. It arbitrates, drives the ALU combinationally from the winner's operands and registers the result into a one-entry response buffer with requester ID and tag. Sits beside the execute stage and is the only instantiator of the ALU.

## Interface
Parameters:
- TAG_W, 4, width of opaque per-request tag returned with the result

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle
- req0_a, req0_b  in  32  port 0 operands (rs1/pc, rs2/imm)
- req0_sel  in  4  port 0 ALU opcode (ALUSel encoding)
- req0_tag  in  TAG_W  port 0 tag
- req1_valid, req1_ready, req1_a, req1_b, req1_sel, req1_tag: same as port 0, for port 1
- rsp_valid  out  1  response buffer holds a result
- rsp_ready  in  1  consumer takes response this cycle
- rsp_data  out  32  ALU result
- rsp_id  out  1  requester that issued it (0/1)
- rsp_tag  out  TAG_W  tag of that request
- rsp_err  out  1  opcode was outside 0x0..0xA

## Operation
- Opcodes: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 xor, 7 slt, 8 sltu, 9 sla, A sra; 0xB..0xF yield result 0 and rsp_err=1.
- can_accept = ~rsp_valid | rsp_ready.
- Grant: when exactly one reqN_valid, that port wins. When both are valid, the winner is set by the arbitration policy (see Configuration).
- reqN_ready = can_accept & grant==N; at most one ready per cycle; ready is never asserted to a non-valid port.
- Transfer on reqN_valid & reqN_ready: the winner's a/b/sel drive the ALU; the result, N, tag and err load into the response buffer; rsp_valid=1.
- A response drains on rsp_valid & rsp_ready. If no new transfer happens in the same cycle, rsp_valid goes to 0 and the data fields hold their last values.
- Drain and a new transfer in the same cycle: the buffer is overwritten, rsp_valid stays 1, and there is no bubble.
- A requester holds valid and payload stable until ready. The arbiter does not retain a grant across cycles.
- Operands pass unmodified. Shift amounts are the full 32-bit b, as the ALU defines.

## Timing
- Latency 1: request accepted in cycle t, rsp_valid and data visible in cycle t+1.
- Throughput: 1 op/cycle while rsp_ready=1.
- req*_ready is combinational from req*_valid, rsp_valid, rsp_ready and the arbiter state. rsp_* are registered only.
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, rsp_tag=0, rsp_err=0, last_grant=1 (port 0 wins first contention).
- Reset mid-operation: a pending response is discarded. Ready is 0 during reset.
- Backpressure: with rsp_valid=1 and rsp_ready=0, both readys are 0 and the buffer holds all fields stable.

## Configuration
- ALU_ARB_ROUND_ROBIN_EN defined: on contention, grant the port not in last_grant. last_grant updates only on a transfer.
- Not defined: fixed priority, port 0 always wins contention. last_grant is not implemented.

## Structure
- Shared package alu_pkg holds:
  - ALUSel opcode constants (ALU_ADD..ALU_SRA)
  - ALU_OP_MAX = 4'hA
  - the response-struct typedef (data, id, tag, err)
- Sub-module: the existing alu, instantiated once. Its inputs are the winner-muxed operands and opcode; its output feeds the response register.

## Test plan
- Port 0 only, add a=5, b=7, tag=3 -> next cycle rsp_valid=1, data=0x0000000C, id=0, tag=3, err=0.
- Port 1 only, sub a=3, b=5 -> data=0xFFFFFFFE, id=1. Then sra a=0x80000000, b=4 -> data=0xF8000000.
- Both valid for 4 consecutive cycles, rsp_ready=1:
  - with ALU_ARB_ROUND_ROBIN_EN, ids are 0,1,0,1;
  - without it, ids are 0,0,0,0 and port 1 gets no ready.
- rsp_ready=0 for 3 cycles with both ports valid -> both readys 0 and rsp_* stable. When rsp_ready=1, drain and accept happen in the same cycle with no bubble.
- Opcode 0xC, a=1, b=1 -> data=0, err=1. Then sltu a=1, b=0xFFFFFFFF -> data=1; slt with the same operands -> data=0.
- Reset asserted while rsp_valid=1 and rsp_ready=0 -> the next cycle rsp_valid=0 and all rsp_* fields are 0. After reset, first contention goes to port 0.
